// File: rtl/salu_pkg.sv
// salu_pkg: shared width default and operation codes for the simple ALU.
//   WIDTH      operand/result width (8).
//   OP_ADD..OP_DEC  operation select codes 4'h0..4'hB; 4'hC..4'hF are reserved.
package salu_pkg;

  localparam int WIDTH = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;

endpackage

// File: rtl/salu_if.sv
// salu_if: bundles the ALU operand/select inputs and registered outputs.
//   operanda, operandb  operands A and B
//   mux                 operation select
//   result, carry, zero registered outputs
// master: the side driving operands (datapath / bench); slave: the ALU.
interface salu_if;
  import salu_pkg::*;

  logic [WIDTH-1:0] operanda;
  logic [WIDTH-1:0] operandb;
  logic [3:0]       mux;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output operanda, operandb, mux,
    input  result, carry, zero
  );

  modport slave (
    input  operanda, operandb, mux,
    output result, carry, zero
  );

endinterface

// File: rtl/salu_comb.sv
// salu_comb: purely combinational ALU core.
//   a, b    operands (b unused by the single-operand ops)
//   op      operation select
//   result  function result
//   carry   carry / borrow / shifted-out bit, 0 for logic and reserved ops
module salu_comb
  import salu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One extra bit on add/sub: bit WIDTH is carry-out for ADD and, with
  // two's-complement subtraction, the borrow for SUB.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_ROL: begin
        result = {a[WIDTH-2:0], a[WIDTH-1]};
        carry  = a[WIDTH-1];
      end
      OP_ROR: begin
        result = {a[0], a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_INC: begin
        result = a + 1'b1;
        carry  = &a;
      end
      OP_DEC: begin
        result = a - 1'b1;
        carry  = ~|a;
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/salu.sv
// salu: 8-bit simple ALU with a single registered output stage.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears result, carry, zero)
//   bus    salu_if.slave: operanda, operandb, mux in; result, carry, zero out
// A new operation is accepted every cycle; outputs reflect the inputs
// sampled at the most recent rising edge.
module salu
  import salu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  salu_if.slave bus
);

  logic [WIDTH-1:0] comb_result;
  logic             comb_carry;

  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             zero_reg;

  salu_comb u_comb (
    .a      (bus.operanda),
    .b      (bus.operandb),
    .op     (bus.mux),
    .result (comb_result),
    .carry  (comb_carry)
  );

  // zero is computed from the value being loaded, so it tracks result in
  // the same cycle (including reserved ops, where result is forced to 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      result_reg <= comb_result;
      carry_reg  <= comb_carry;
      zero_reg   <= (comb_result == '0);
    end
  end

  assign bus.result = result_reg;
  assign bus.carry  = carry_reg;
  assign bus.zero   = zero_reg;

endmodule

// File: tb/tb_salu.sv
module tb_salu;

  logic clk;
  logic rst_n;

  salu_if bus ();

  salu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic       c;
    logic       z;
  } vec_t;

  vec_t tbl[$];
  int n_vec;
  int n_bad;

  // Reference model: ALU rules evaluated with plain integer arithmetic.
  function automatic void model(input int a, input int b, input int op,
                                output int r, output int c);
    r = 0;
    c = 0;
    case (op)
      0:  begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  begin r = (a * 2) % 256; c = a / 128; end
      7:  begin r = a / 2; c = a % 2; end
      8:  begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      9:  begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      10: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
      11: begin r = (a + 255) % 256; c = (a == 0) ? 1 : 0; end
      default: begin r = 0; c = 0; end
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] er,
                       input logic ec, input logic ez);
    n_vec++;
    if (bus.result !== er || bus.carry !== ec || bus.zero !== ez) begin
      n_bad++;
      $display("FAIL %s: got R=%02h C=%0b Z=%0b, want R=%02h C=%0b Z=%0b",
               name, bus.result, bus.carry, bus.zero, er, ec, ez);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.operanda = a;
    bus.operandb = b;
    bus.mux      = op;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] r, input logic c, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.r = r; v.c = c; v.z = z;
    tbl.push_back(v);
  endtask

  initial begin
    int mr, mc;
    logic [7:0] ra, rb;
    logic [3:0] rop;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.operanda = 8'h6A;
    bus.operandb = 8'h3B;
    bus.mux      = 4'h0;

    // Reset held across edges keeps outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed expectations.
    add_vec(8'h6A, 8'h3B, 4'h0, 8'hA5, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h1, 8'h2F, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h2, 8'h2A, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h3, 8'h7B, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h4, 8'h51, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h5, 8'h95, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h6, 8'hD4, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h7, 8'h35, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h8, 8'hD4, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'h9, 8'h35, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'hA, 8'h6B, 1'b0, 1'b0);
    add_vec(8'h6A, 8'h3B, 4'hB, 8'h69, 1'b0, 1'b0);
    add_vec(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1);
    add_vec(8'hFF, 8'h01, 4'hA, 8'h00, 1'b1, 1'b1);
    add_vec(8'h00, 8'h01, 4'h1, 8'hFF, 1'b1, 1'b0);
    add_vec(8'h00, 8'h01, 4'hB, 8'hFF, 1'b1, 1'b0);
    add_vec(8'h81, 8'h00, 4'h8, 8'h03, 1'b1, 1'b0);
    add_vec(8'h81, 8'h00, 4'h9, 8'hC0, 1'b1, 1'b0);
    add_vec(8'h55, 8'hAA, 4'h2, 8'h00, 1'b0, 1'b1);
    add_vec(8'h80, 8'h00, 4'h6, 8'h00, 1'b1, 1'b1);
    add_vec(8'h01, 8'h00, 4'h7, 8'h00, 1'b1, 1'b1);
    add_vec(8'h5A, 8'h5A, 4'h4, 8'h00, 1'b0, 1'b1);
    add_vec(8'hFF, 8'hFF, 4'hC, 8'h00, 1'b0, 1'b1);
    add_vec(8'h12, 8'h34, 4'hD, 8'h00, 1'b0, 1'b1);
    add_vec(8'hA5, 8'h5A, 4'hE, 8'h00, 1'b0, 1'b1);
    add_vec(8'h80, 8'h80, 4'hF, 8'h00, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].op);
      $display("vec %0d: A=%02h B=%02h op=%h -> R=%02h C=%0b Z=%0b",
               i, tbl[i].a, tbl[i].b, tbl[i].op, bus.result, bus.carry, bus.zero);
      check($sformatf("table[%0d]", i), tbl[i].r, tbl[i].c, tbl[i].z);
    end

    // Latency: an input change is not visible until the next rising edge.
    apply(8'h6A, 8'h3B, 4'h0);
    check("lat_before", 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    bus.mux = 4'h1;
    #1;
    check("lat_hold", 8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("lat_after", 8'h2F, 1'b0, 1'b0);

    // Mid-cycle reset clears outputs immediately, without a clock edge.
    apply(8'hFF, 8'h01, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.operanda = 8'h6A;
    bus.operandb = 8'h3B;
    bus.mux      = 4'h3;
    @(posedge clk);
    #1;
    check("reset_held_edge", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_release", 8'h7B, 1'b0, 1'b0);

    // Randomized ops against the reference model.
    for (int k = 0; k < 300; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      if (k % 16 == 0) ra = 8'hFF;
      if (k % 16 == 1) ra = 8'h00;
      apply(ra, rb, rop);
      model(int'(ra), int'(rb), int'(rop), mr, mc);
      $display("rnd %0d: A=%02h B=%02h op=%h -> R=%02h C=%0b Z=%0b",
               k, ra, rb, rop, bus.result, bus.carry, bus.zero);
      check($sformatf("rand[%0d]", k), 8'(mr), mc[0], (mr == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
